id_regfile_stage: RTL and testbench

Parametrised decode-stage register file with an in-flight-write scoreboard and a valid/ready ID/EX output register. It replaces the fixed 32×32, two-read, one-write GRF and its stall/clear logic in the decode stage. It supports N read ports, M write-back ports, and counted pending writes per register. The scoreboard lets the stage detect its own hazards instead of relying on an external hazard unit.

---
 rtl/id_regfile_stage_pkg.sv | 15 +
 rtl/id_scoreboard.sv | 65 ++++++
 rtl/id_regfile_stage.sv | 94 +++++++++
 tb/tb_id_regfile_stage.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/id_regfile_stage_pkg.sv
// id_regfile_stage_pkg: shared width helpers and decode payload field layout used by EX.
package id_regfile_stage_pkg;
    localparam int PAY_INSTR_LSB = 0;
    localparam int PAY_INSTR_W   = 32;
    localparam int PAY_PC_LSB    = 32;
    localparam int PAY_PC_W      = 32;

    function automatic int max2(input int a, input int b);
        return a > b ? a : b;
    endfunction

    function automatic int cnt_w(input int n);
        return $clog2(n + 1);
    endfunction
endpackage

// File: rtl/id_scoreboard.sv
// id_scoreboard: per-register pending-write counters, issue hazard and sticky underflow flag.
module id_scoreboard
    import id_regfile_stage_pkg::*;
#(
    parameter int NREG = 32,
    parameter int NRP  = 2,
    parameter int NWP  = 2,
    parameter int CNTW = 2,
    parameter int AW   = $clog2(NREG)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    input  logic [NRP*AW-1:0] in_rs,
    input  logic [AW-1:0]     in_rd,
    input  logic              in_we,
    input  logic              issue,
    input  logic [NWP-1:0]    rel,
    input  logic [NWP*AW-1:0] wb_addr,
    input  logic              kill,
    input  logic [AW-1:0]     kill_rd,
    output logic              hazard,
    output logic              sb_err
);
    localparam int DW = cnt_w(NWP + 1);
    localparam int SW = max2(CNTW, DW) + 1;

    logic [CNTW-1:0] cnt    [NREG];
    logic [CNTW-1:0] cnt_nx [NREG];
    logic [SW-1:0]   dec    [NREG];
    logic [SW-1:0]   sum    [NREG];
    logic [NREG-1:0] uflow;

    // a squashed ID/EX entry releases its own pending write like one more wb port
    always_comb begin
        for (int r = 0; r < NREG; r++) begin
            dec[r] = SW'(kill && kill_rd == AW'(r) && r != 0);
            for (int j = 0; j < NWP; j++)
                dec[r] = dec[r] + SW'(rel[j] && wb_addr[j*AW +: AW] == AW'(r) && r != 0);
            sum[r]    = SW'(cnt[r]) + SW'(issue && in_we && in_rd == AW'(r) && r != 0);
            uflow[r]  = dec[r] > sum[r];
            cnt_nx[r] = uflow[r] ? '0 : CNTW'(sum[r] - dec[r]);
        end
    end

    always_comb begin
        hazard = in_we && in_rd != '0 && cnt[in_rd] == '1;
        for (int i = 0; i < NRP; i++)
            if (in_rs[i*AW +: AW] != '0 && SW'(cnt[in_rs[i*AW +: AW]]) > dec[in_rs[i*AW +: AW]])
                hazard = 1'b1;
        hazard = hazard && in_valid && !reset;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int r = 0; r < NREG; r++)
                cnt[r] <= '0;
            sb_err <= 1'b0;
        end else begin
            for (int r = 0; r < NREG; r++)
                cnt[r] <= cnt_nx[r];
            sb_err <= sb_err || (|uflow);
        end
    end
endmodule

// File: rtl/id_regfile_stage.sv
// id_regfile_stage: decode register file with write-back bypass, write scoreboard and ID/EX register.
module id_regfile_stage
    import id_regfile_stage_pkg::*;
#(
    parameter int  XLEN = 32,
    parameter int  NREG = 32,
    parameter int  NRP  = 2,
    parameter int  NWP  = 2,
    parameter int  CNTW = 2,
    parameter int  PAYW = 64,
    localparam int AW   = $clog2(NREG)
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [NRP*AW-1:0]   in_rs,
    input  logic [AW-1:0]       in_rd,
    input  logic                in_we,
    input  logic [PAYW-1:0]     in_pay,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [NRP*XLEN-1:0] out_rsv,
    output logic [AW-1:0]       out_rd,
    output logic                out_we,
    output logic [PAYW-1:0]     out_pay,
    input  logic                flush,
    input  logic [NWP-1:0]      wb_rel,
    input  logic [NWP-1:0]      wb_we,
    input  logic [NWP*AW-1:0]   wb_addr,
    input  logic [NWP*XLEN-1:0] wb_data,
    output logic                hazard,
    output logic                sb_err
);
    logic [XLEN-1:0]     rf [NREG];
    logic [NRP*XLEN-1:0] rsv;
    logic [NWP-1:0]      rel;
    logic                issue, kill;

    assign rel      = reset ? '0 : wb_rel | wb_we;
    assign in_ready = !reset && !flush && !hazard && (!out_valid || out_ready);
    assign issue    = in_valid && in_ready;
    assign kill     = flush && out_valid && out_we && out_rd != '0 && !out_ready;

    id_scoreboard #(.NREG(NREG), .NRP(NRP), .NWP(NWP), .CNTW(CNTW), .AW(AW)) u_sb (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_rs(in_rs), .in_rd(in_rd),
        .in_we(in_we), .issue(issue), .rel(rel), .wb_addr(wb_addr), .kill(kill),
        .kill_rd(out_rd), .hazard(hazard), .sb_err(sb_err)
    );

    // later wb ports override earlier ones, so the highest index wins the bypass
    always_comb begin
        rsv = '0;
        for (int i = 0; i < NRP; i++) begin
            rsv[i*XLEN +: XLEN] = rf[in_rs[i*AW +: AW]];
            for (int j = 0; j < NWP; j++)
                if (wb_we[j] && wb_addr[j*AW +: AW] == in_rs[i*AW +: AW])
                    rsv[i*XLEN +: XLEN] = wb_data[j*XLEN +: XLEN];
            if (in_rs[i*AW +: AW] == '0)
                rsv[i*XLEN +: XLEN] = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int r = 0; r < NREG; r++)
                rf[r] <= '0;
        end else begin
            for (int j = 0; j < NWP; j++)
                if (wb_we[j] && wb_addr[j*AW +: AW] != '0)
                    rf[wb_addr[j*AW +: AW]] <= wb_data[j*XLEN +: XLEN];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            out_valid <= 1'b0;
            out_rsv   <= '0;
            out_rd    <= '0;
            out_we    <= 1'b0;
            out_pay   <= '0;
        end else if (flush) begin
            out_valid <= 1'b0;
        end else if (issue) begin
            out_valid <= 1'b1;
            out_rsv   <= rsv;
            out_rd    <= in_rd;
            out_we    <= in_we;
            out_pay   <= in_pay;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end
endmodule

// File: tb/tb_id_regfile_stage.sv
// tb_id_regfile_stage: random and directed stimulus against a register/pending-count reference model.
module tb_id_regfile_stage;
    import id_regfile_stage_pkg::*;
    localparam int XLEN = 32, NREG = 32, NRP = 2, NWP = 2, CNTW = 2, PAYW = 64, AW = 5;
    localparam int CMAX = (1 << CNTW) - 1;

    logic clk = 1'b0;
    logic reset, in_valid, in_ready, in_we, out_valid, out_ready, out_we, flush, hazard, sb_err;
    logic [NRP*AW-1:0]   in_rs;
    logic [AW-1:0]       in_rd, out_rd;
    logic [PAYW-1:0]     in_pay, out_pay;
    logic [NRP*XLEN-1:0] out_rsv;
    logic [NWP-1:0]      wb_rel, wb_we;
    logic [NWP*AW-1:0]   wb_addr;
    logic [NWP*XLEN-1:0] wb_data;

    always #5 clk = ~clk;

    id_regfile_stage #(.XLEN(XLEN), .NREG(NREG), .NRP(NRP), .NWP(NWP), .CNTW(CNTW), .PAYW(PAYW)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready), .in_rs(in_rs),
        .in_rd(in_rd), .in_we(in_we), .in_pay(in_pay), .out_valid(out_valid), .out_ready(out_ready),
        .out_rsv(out_rsv), .out_rd(out_rd), .out_we(out_we), .out_pay(out_pay), .flush(flush),
        .wb_rel(wb_rel), .wb_we(wb_we), .wb_addr(wb_addr), .wb_data(wb_data), .hazard(hazard),
        .sb_err(sb_err)
    );

    typedef struct {
        logic [NRP*XLEN-1:0] rsv;
        logic [AW-1:0]       rd;
        logic                we;
        logic [PAYW-1:0]     pay;
    } ent_t;

    ent_t exp_q[$];
    int tests = 0, fails = 0;
    logic [XLEN-1:0] regs [NREG];
    int pend [NREG];
    bit err, mvalid, mwe, mon_en;
    logic [AW-1:0] mrd;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // monitor: compares the ID/EX entry against the scoreboard queue, pops when EX takes it
    initial forever begin
        @(negedge clk);
        if (mon_en) begin
            chk("out_valid", out_valid, exp_q.size() != 0);
            if (out_valid && exp_q.size() != 0) begin
                chk("out_rsv", out_rsv, exp_q[0].rsv);
                chk("out_rd", out_rd, exp_q[0].rd);
                chk("out_we", out_we, exp_q[0].we);
                chk("out_pay", out_pay, exp_q[0].pay);
                if (out_ready) void'(exp_q.pop_front());
            end
        end
    end

    task automatic idle();
        in_valid = 0; in_rs = '0; in_rd = '0; in_we = 0; in_pay = '0; out_ready = 1;
        flush = 0; wb_rel = '0; wb_we = '0; wb_addr = '0; wb_data = '0;
    endtask

    // one clock: predict hazard/ready, queue the expected entry, advance the model
    task automatic step();
        int rels [NREG];
        bit kill, hz, rdy, iss;
        ent_t e;
        logic [AW-1:0] a, s;
        int n;
        @(negedge clk); #1;
        foreach (rels[r]) rels[r] = 0;
        kill = !reset && flush && mvalid && mwe && mrd != 0 && !out_ready;
        if (!reset)
            for (int j = 0; j < NWP; j++) begin
                a = wb_addr[j*AW +: AW];
                if ((wb_rel[j] || wb_we[j]) && a != 0) rels[a]++;
            end
        if (kill) rels[mrd]++;
        hz = 0;
        if (in_valid && !reset) begin
            for (int i = 0; i < NRP; i++) begin
                s = in_rs[i*AW +: AW];
                if (s != 0 && pend[s] - rels[s] > 0) hz = 1;
            end
            if (in_we && in_rd != 0 && pend[in_rd] == CMAX) hz = 1;
        end
        rdy = !reset && !flush && !hz && (!mvalid || out_ready);
        chk("hazard", hazard, hz);
        chk("in_ready", in_ready, rdy);
        iss = in_valid && rdy;
        if (iss) begin
            e.rsv = '0;
            for (int i = 0; i < NRP; i++) begin
                s = in_rs[i*AW +: AW];
                e.rsv[i*XLEN +: XLEN] = regs[s];
                for (int j = 0; j < NWP; j++)
                    if (wb_we[j] && wb_addr[j*AW +: AW] == s) e.rsv[i*XLEN +: XLEN] = wb_data[j*XLEN +: XLEN];
                if (s == 0) e.rsv[i*XLEN +: XLEN] = '0;
            end
            e.rd = in_rd; e.we = in_we; e.pay = in_pay;
            exp_q.push_back(e);
        end
        if (reset) begin
            foreach (regs[r]) begin regs[r] = '0; pend[r] = 0; end
            exp_q.delete();
            err = 0; mvalid = 0; mwe = 0; mrd = '0;
        end else begin
            if (flush && mvalid && !out_ready && exp_q.size() != 0) void'(exp_q.pop_front());
            for (int j = 0; j < NWP; j++)
                if (wb_we[j] && wb_addr[j*AW +: AW] != 0) regs[wb_addr[j*AW +: AW]] = wb_data[j*XLEN +: XLEN];
            for (int r = 1; r < NREG; r++) begin
                n = pend[r] + ((iss && in_we && in_rd == AW'(r)) ? 1 : 0) - rels[r];
                if (n < 0) begin n = 0; err = 1; end
                pend[r] = n;
            end
            mvalid = flush ? 0 : iss ? 1 : out_ready ? 0 : mvalid;
            if (iss) begin mrd = in_rd; mwe = in_we; end
        end
        @(posedge clk); #1;
        chk("sb_err", sb_err, err);
    endtask

    initial begin
        logic [AW-1:0] pl[$];
        logic [AW-1:0] addr;
        idle();
        reset = 1; mon_en = 0;
        @(posedge clk); #1;
        step(); step();
        reset = 0; mon_en = 1;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_rsv", out_rsv, 0);
        chk("rst_sb_err", sb_err, 0);

        idle(); wb_we = 2'b01; wb_addr = {5'd0, 5'd5}; wb_data = {32'd0, 32'hDEADBEEF};
        in_valid = 1; in_rs = {5'd0, 5'd5}; in_pay = 64'h1; step();
        chk("wt_rsv0", out_rsv[31:0], 32'hDEADBEEF);

        idle(); in_valid = 1; in_rd = 5'd8; in_we = 1; in_pay = 64'h2; step();
        idle(); in_valid = 1; in_rs = {5'd8, 5'd0}; in_pay = 64'h3; #1;
        chk("hz_set", hazard, 1); chk("hz_block", in_ready, 0);
        step(); step();
        wb_we = 2'b01; wb_addr = {5'd0, 5'd8}; wb_data = {32'd0, 32'h1234}; #1;
        chk("hz_clear", in_ready, 1);
        step();
        chk("hz_rsv1", out_rsv[63:32], 32'h1234);

        idle(); in_valid = 1; in_rd = 5'd3; in_we = 1; repeat (3) step();
        #1 chk("sat_hz", hazard, 1);
        step();
        wb_rel = 2'b01; wb_addr = {5'd0, 5'd3}; step();
        wb_rel = '0; #1 chk("sat_go", in_ready, 1);
        step();

        idle(); in_valid = 1; in_rd = 5'd7; in_we = 1; repeat (2) step();
        idle(); wb_we = 2'b11; wb_addr = {5'd7, 5'd7}; wb_data = {32'h22, 32'h11}; step();
        idle(); in_valid = 1; in_rs = {5'd0, 5'd7}; #1 chk("pc_nohz", hazard, 0);
        step();
        chk("pc_rsv0", out_rsv[31:0], 32'h22);

        idle(); out_ready = 0; in_valid = 1; in_rd = 5'd9; in_we = 1; step();
        chk("fl_valid", out_valid, 1);
        idle(); out_ready = 0; flush = 1; in_valid = 1; in_rs = {5'd0, 5'd9}; #1 chk("fl_rdy", in_ready, 0);
        step();
        chk("fl_valid0", out_valid, 0);
        flush = 0; #1 chk("fl_hz", hazard, 0);
        step();
        idle(); step();

        idle(); wb_we = 2'b01; wb_addr = {5'd0, 5'd4}; wb_data = {32'd0, 32'h55}; step();
        chk("uf_err", sb_err, 1);
        idle(); repeat (3) step();
        chk("uf_sticky", sb_err, 1);
        reset = 1; step(); reset = 0;
        chk("rst_err", sb_err, 0);
        in_valid = 1; in_rs = {5'd0, 5'd4}; step();
        chk("rst_reg4", out_rsv[31:0], 32'd0);

        for (int c = 0; c < 3000; c++) begin
            idle();
            reset = $urandom_range(0, 299) == 0;
            in_valid = $urandom_range(0, 3) != 0;
            in_rs = {AW'($urandom_range(0, 7)), AW'($urandom_range(0, 7))};
            in_rd = AW'($urandom_range(0, 7));
            in_we = 1'($urandom_range(0, 1));
            in_pay = {$urandom, $urandom};
            out_ready = $urandom_range(0, 3) != 0;
            flush = $urandom_range(0, 15) == 0;
            pl.delete();
            for (int r = 1; r < NREG; r++) if (pend[r] > 0) pl.push_back(AW'(r));
            for (int j = 0; j < NWP; j++)
                if ($urandom_range(0, 1) == 1) begin
                    addr = (pl.size() != 0 && $urandom_range(0, 15) != 0)
                         ? pl[$urandom_range(0, pl.size() - 1)] : AW'($urandom_range(0, 7));
                    if ($urandom_range(0, 1) == 1) wb_we[j] = 1; else wb_rel[j] = 1;
                    wb_addr[j*AW +: AW] = addr;
                    wb_data[j*XLEN +: XLEN] = $urandom;
                end
            step();
        end
        reset = 0; idle(); repeat (4) step();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
